// File: rtl/cla_pkg.sv
// Shared definitions for the shared carry-lookahead adder slice.
//   DATA_W  : default operand/sum width of the shared adder
//   clog2() : ceiling log2 (minimum 1), used to size requester IDs
//   op_t    : stage-1 operation record {a, b, cin, id}
package cla_pkg;

  localparam int DATA_W = 65;

  // Largest supported requester count; sizes the ID field of op_t.
  localparam int MAX_REQ = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

  localparam int OP_ID_W = clog2(MAX_REQ);

  typedef struct packed {
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic               cin;
    logic [OP_ID_W-1:0] id;
  } op_t;

endpackage

// File: rtl/cla65_share_arb_if.sv
// Requester and result handshake bundle for cla65_share_arb.
//   req_valid/req_ready : per-requester operand handshake (ready one-hot or zero)
//   req_a/req_b/req_cin : packed operands, requester i at [i*DATA_W +: DATA_W]
//   res_*               : tagged result with valid/ready
// slave is the arbiter's view, master is the requester/consumer view.
interface cla65_share_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 65,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_cin;
  logic                      res_valid;
  logic                      res_ready;
  logic [DATA_W-1:0]         res_sum;
  logic                      res_cout;
  logic [ID_W-1:0]           res_id;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, res_ready,
    output req_ready, res_valid, res_sum, res_cout, res_id
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, res_ready,
    input  req_ready, res_valid, res_sum, res_cout, res_id
  );
endinterface

// File: rtl/cla65_share_arb_cla.sv
// Carry-lookahead adder: {cout, sum} = a + b + cin, no clock.
// 4-bit lookahead groups; group generate/propagate chain the group carries.
//   a, b : operands      cin  : carry in
//   sum  : DATA_W bits   cout : carry out of the MSB
module cla65 #(
  parameter int DATA_W = 65
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  // At least one zero pad bit above the MSB: its sum bit is the carry out.
  localparam int NG = DATA_W / 4 + 1;
  localparam int PW = NG * 4;

  logic [PW-1:0] a_p, b_p, g, p, c_v, s_p;
  logic          c;

  assign a_p = PW'(a);
  assign b_p = PW'(b);
  assign g   = a_p & b_p;
  assign p   = a_p ^ b_p;

  always_comb begin
    c   = cin;
    c_v = '0;
    for (int gi = 0; gi < NG; gi++) begin
      c_v[4*gi]   = c;
      c_v[4*gi+1] = g[4*gi] | (p[4*gi] & c);
      c_v[4*gi+2] = g[4*gi+1] | (p[4*gi+1] & g[4*gi])
                  | (p[4*gi+1] & p[4*gi] & c);
      c_v[4*gi+3] = g[4*gi+2] | (p[4*gi+2] & g[4*gi+1])
                  | (p[4*gi+2] & p[4*gi+1] & g[4*gi])
                  | (p[4*gi+2] & p[4*gi+1] & p[4*gi] & c);
      // Group carry out from group generate/propagate.
      c = (g[4*gi+3] | (p[4*gi+3] & g[4*gi+2])
          | (p[4*gi+3] & p[4*gi+2] & g[4*gi+1])
          | (p[4*gi+3] & p[4*gi+2] & p[4*gi+1] & g[4*gi]))
        | (&p[4*gi +: 4] & c);
    end
  end

  assign s_p  = p ^ c_v;
  assign sum  = s_p[DATA_W-1:0];
  assign cout = s_p[DATA_W];

endmodule

// File: rtl/cla65_share_arb_rr_arb.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : index searched first (circular search upward from here)
//   en    : grant allowed this cycle
//   grant : one-hot grant, zero when en=0 or no request
//   idx   : encoded index of the granted requester
//   any   : a grant was issued
module rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  int j;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    if (en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = int'(ptr) + k;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        if (!any && req[j]) begin
          any      = 1'b1;
          grant[j] = 1'b1;
          idx      = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/cla65_share_arb.sv
// Round-robin share of one carry-lookahead adder between NUM_REQ requesters.
// Stage 1 registers the granted operands, stage 2 registers the sum tagged
// with the requester index. Both stages stall under result backpressure.
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active HIGH despite the name
//   bus   : requester/result handshakes (slave modport)
//   busy  : an operation sits in stage 1 or stage 2
module cla65_share_arb
  import cla_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = cla_pkg::DATA_W,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cla65_share_arb_if.slave        bus,
  output logic                    busy
);

  logic              s1_en, s2_en;
  logic              op_valid;
  op_t               op;
  logic [ID_W-1:0]   rr_ptr, ptr_nxt, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic              gnt_any;
  logic [DATA_W-1:0] add_sum;
  logic              add_cout;

  logic              res_valid_q;
  logic [DATA_W-1:0] res_sum_q;
  logic              res_cout_q;
  logic [ID_W-1:0]   res_id_q;

  assign s2_en = !res_valid_q || bus.res_ready;
  assign s1_en = !op_valid || s2_en;

  // Arbitration is masked while reset is asserted so nothing is accepted.
  rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .en    (s1_en && !rst_n),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign bus.req_ready = gnt;
  assign ptr_nxt = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // NOTE: operand registers carry no reset; op_valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (gnt_any) begin
      op.a   <= bus.req_a[gnt_idx*DATA_W +: DATA_W];
      op.b   <= bus.req_b[gnt_idx*DATA_W +: DATA_W];
      op.cin <= bus.req_cin[gnt_idx];
      op.id  <= OP_ID_W'(gnt_idx);
    end
  end

  cla65 #(.DATA_W(DATA_W)) u_add (
    .a    (op.a),
    .b    (op.b),
    .cin  (op.cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // NOTE: non-blocking assignments so stage 2 samples stage 1's old content
  // in the same edge that stage 1 loads the new grant.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      op_valid    <= 1'b0;
      rr_ptr      <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_id_q    <= '0;
    end else begin
      if (s1_en) begin
        op_valid <= gnt_any;
        if (gnt_any) rr_ptr <= ptr_nxt;
      end
      if (s2_en) begin
        res_valid_q <= op_valid;
        res_sum_q   <= add_sum;
        res_cout_q  <= add_cout;
        res_id_q    <= ID_W'(op.id);
      end
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_cout  = res_cout_q;
  assign bus.res_id    = res_id_q;
  assign busy          = op_valid || res_valid_q;

endmodule

// File: tb/tb_cla65_share_arb.sv
// Bench for cla65_share_arb: directed scenarios plus random traffic, each
// cycle checked against a two-slot pipeline model with plain-arithmetic sums.
module tb_cla65_share_arb;

  localparam int NR = 4;
  localparam int DW = 65;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  cla65_share_arb_if #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) bus ();

  cla65_share_arb #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  typedef struct {
    bit            v;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          cin;
    int            id;
  } mop_t;

  mop_t m1, m2;
  int   mptr;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   gq[$];   // model grant order
  int   og[$];   // observed grants (from req_ready)
  int   dq[$];   // observed completed result ids

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW:0] ref_add(input mop_t o);
    logic [DW:0] r;
    r = {1'b0, o.a};
    r = r + {1'b0, o.b} + {{DW{1'b0}}, o.cin};
    return r;
  endfunction

  function automatic logic [DW-1:0] rand65();
    logic [95:0] w;
    logic [DW-1:0] r;
    w = {$urandom, $urandom, $urandom};
    case ($urandom_range(0, 5))
      0:       r = '1;
      1:       r = {1'b1, {(DW-1){1'b0}}};
      2:       r = '0;
      default: r = w[DW-1:0];
    endcase
    return r;
  endfunction

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cin);
    bus.req_a[i*DW +: DW] = a;
    bus.req_b[i*DW +: DW] = b;
    bus.req_cin[i]        = cin;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) set_op(i, rand65(), rand65(), 1'($urandom_range(0, 1)));
  endtask

  task automatic model_reset();
    m1.v = 1'b0;
    m2.v = 1'b0;
    mptr = 0;
    while (gq.size() > dq.size()) void'(gq.pop_back());
  endtask

  // One clock: check the combinational grant, advance, check registered outputs.
  task automatic step();
    bit          s1e, s2e;
    int          g, j;
    logic [NR-1:0] er;
    mop_t        nxt;
    logic [DW:0] r;
    #3;
    s2e = !m2.v || bus.res_ready;
    s1e = !m1.v || s2e;
    g = -1;
    if (s1e) begin
      for (int k = 0; k < NR; k++) begin
        j = (mptr + k) % NR;
        if (g < 0 && bus.req_valid[j]) g = j;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", 128'(bus.req_ready), 128'(er));
    for (int k = 0; k < NR; k++) if (bus.req_ready[k]) og.push_back(k);
    if (m2.v && bus.res_ready) dq.push_back(int'(bus.res_id));
    nxt.v = 1'b1;
    nxt.id = g;
    if (g >= 0) begin
      nxt.a   = bus.req_a[g*DW +: DW];
      nxt.b   = bus.req_b[g*DW +: DW];
      nxt.cin = bus.req_cin[g];
    end
    @(posedge clk);
    #1;
    if (s2e) m2 = m1;
    if (s1e) begin
      m1.v = (g >= 0);
      if (g >= 0) begin
        m1 = nxt;
        mptr = (g + 1) % NR;
        gq.push_back(g);
      end
    end
    check("res_valid", 128'(bus.res_valid), 128'(m2.v));
    check("busy", 128'(busy), 128'(m1.v || m2.v));
    if (m2.v) begin
      r = ref_add(m2);
      check("res_sum", 128'(bus.res_sum), 128'(r[DW-1:0]));
      check("res_cout", 128'(bus.res_cout), 128'(r[DW]));
      check("res_id", 128'(bus.res_id), 128'(m2.id));
    end
  endtask

  initial begin
    int exp_g[5];
    int s, d0;
    logic [NR-1:0] pend;
    logic [DW-1:0] big;

    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_cin = '0;
    bus.res_ready = 1'b0;
    model_reset();

    // Reset state, including no grant while requests are pending in reset.
    #2;
    bus.req_valid = '1;
    #1;
    check("rst_req_ready", 128'(bus.req_ready), 128'(0));
    check("rst_res_valid", 128'(bus.res_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_res_sum", 128'(bus.res_sum), 128'(0));
    check("rst_res_id", 128'(bus.res_id), 128'(0));
    check("rst_res_cout", 128'(bus.res_cout), 128'(0));
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;

    // All four requesters held: grants rotate 0,1,2,3,0.
    exp_g = '{0, 1, 2, 3, 0};
    rand_ops();
    bus.res_ready = 1'b1;
    bus.req_valid = '1;
    s = og.size();
    for (int i = 0; i < 5; i++) step();
    for (int i = 0; i < 5; i++) check("rr_order", 128'(og[s+i]), 128'(exp_g[i]));
    bus.req_valid = '0;
    step();
    step();

    // Single request: 5 + 7 + 1 = 13 on requester 0.
    set_op(0, 65'd5, 65'd7, 1'b1);
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    step();
    check("t1_valid", 128'(bus.res_valid), 128'(1));
    check("t1_sum", 128'(bus.res_sum), 128'(13));
    check("t1_cout", 128'(bus.res_cout), 128'(0));
    check("t1_id", 128'(bus.res_id), 128'(0));

    // Carry boundaries.
    big = {1'b1, {(DW-1){1'b0}}};
    set_op(0, '1, '0, 1'b1);
    set_op(1, big, big, 1'b0);
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = 4'b0010;
    step();
    check("cy1_sum", 128'(bus.res_sum), 128'(0));
    check("cy1_cout", 128'(bus.res_cout), 128'(1));
    bus.req_valid = '0;
    step();
    check("cy2_sum", 128'(bus.res_sum), 128'(0));
    check("cy2_cout", 128'(bus.res_cout), 128'(1));
    check("cy2_id", 128'(bus.res_id), 128'(1));
    step();

    // Backpressure: three requesters, result port stalled for five cycles.
    rand_ops();
    bus.res_ready = 1'b0;
    pend = 4'b0111;
    s = og.size();
    d0 = dq.size();
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = pend;
      step();
      if (og.size() > s && bus.req_valid[og[$]]) pend[og[$]] = 1'b0;
    end
    check("bp_accepted", 128'(og.size() - s), 128'(2));
    bus.res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = pend;
      step();
      if (og.size() > 0 && pend[og[$]] && bus.req_valid[og[$]]) pend[og[$]] = 1'b0;
    end
    bus.req_valid = '0;
    check("bp_delivered", 128'(dq.size() - d0), 128'(3));

    // Reset with both stages full.
    bus.res_ready = 1'b0;
    pend = 4'b1100;
    for (int i = 0; i < 2; i++) begin
      bus.req_valid = pend;
      step();
      if (og.size() > 0) pend[og[$]] = 1'b0;
    end
    bus.req_valid = '0;
    #2;
    rst_n = 1'b1;
    #1;
    check("mrst_res_valid", 128'(bus.res_valid), 128'(0));
    check("mrst_busy", 128'(busy), 128'(0));
    check("mrst_req_ready", 128'(bus.req_ready), 128'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rand_ops();
    bus.req_valid = '1;
    bus.res_ready = 1'b1;
    step();
    check("mrst_prio", 128'(og[$]), 128'(0));
    bus.req_valid = '0;
    for (int i = 0; i < 3; i++) step();

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      bus.req_valid = NR'($urandom_range(0, 15));
      bus.res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // No loss, no duplication, grant order preserved.
    check("drain_count", 128'(dq.size()), 128'(gq.size()));
    for (int i = 0; i < dq.size() && i < gq.size(); i++)
      check("result_order", 128'(dq[i]), 128'(gq[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
